// File: rtl/r_cpu_pkg.sv
// Shared definitions for the R-type CPU front end: fetch FSM encoding,
// instruction-register field positions and reset/step defaults.
package r_cpu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF  = 4;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] func;
  } r_fields_t;

  function automatic r_fields_t split_ir(input logic [31:0] ir);
    r_fields_t f;
    f.op    = ir[OP_MSB:OP_LSB];
    f.rs    = ir[RS_MSB:RS_LSB];
    f.rt    = ir[RT_MSB:RT_LSB];
    f.rd    = ir[RD_MSB:RD_LSB];
    f.shamt = ir[SHAMT_MSB:SHAMT_LSB];
    f.func  = ir[FUNC_MSB:FUNC_LSB];
    return f;
  endfunction

endpackage

// File: rtl/r_inst_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the IR hand-off to decode.
// master = fetch stage, slave = memory/decode side.
interface r_inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic              ir_valid;
  logic              ir_ready;
  logic [5:0]        OP;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        func;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  inst_cnt;

  modport master (
    output imem_req, imem_addr, ir_valid, OP, rs, rt, rd, shamt, func, pc, inst_cnt,
    input  imem_rdata, imem_ready, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, OP, rs, rt, rd, shamt, func, pc, inst_cnt,
    output imem_rdata, imem_ready, ir_ready
  );
endinterface

// File: rtl/r_pc_counter.sv
// Program-counter pair: pc_q tracks the instruction in IR, pc_next_q the next
// address to fetch. Both advance together on step_i and wrap modulo 2^ADDR_W.
module r_pc_counter #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;

  assign pc_d      = step_i ? pc_next_q : pc_q;
  assign pc_next_d = step_i ? pc_next_q + ADDR_W'(PC_STEP) : pc_next_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pc_next_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_next_q;

endmodule

// File: rtl/r_inst_fetch.sv
// Instruction-fetch stage: requests one word per fetch, latches it into IR and
// offers the split R-type fields to decode with valid/ready; counts accepted instructions.
module r_inst_fetch
  import r_cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                PC_STEP  = PC_STEP_DEF,
  parameter int                CNT_W    = 32
) (
  input logic            clk,
  input logic            rst_n,
  input logic            run,
  r_inst_fetch_if.master bus
);

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic [1:0]        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_done;
  logic              accept;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  r_fields_t         fields;

  // NOTE: reset asserts asynchronously but releases through two flops, so every register leaves reset on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign fetch_done = (state_q == ST_REQ)  && bus.imem_ready;
  assign accept     = (state_q == ST_HOLD) && bus.ir_ready;

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run)            state_d = ST_REQ;
      ST_REQ:  if (bus.imem_ready) state_d = ST_HOLD;
      ST_HOLD: if (bus.ir_ready)   state_d = run ? ST_REQ : ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  assign ir_d  = fetch_done ? bus.imem_rdata : ir_q;
  assign cnt_d = accept ? cnt_q + CNT_W'(1) : cnt_q;

  // NOTE: non-blocking assignments make every register sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  r_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .step_i    (fetch_done),
    .pc_o      (pc),
    .pc_next_o (pc_next)
  );

  // Fields come only from the registered IR, never straight from imem_rdata.
  assign fields = split_ir(ir_q);

  assign bus.imem_req  = (state_q == ST_REQ);
  assign bus.imem_addr = pc_next;
  assign bus.ir_valid  = (state_q == ST_HOLD);
  assign bus.OP        = fields.op;
  assign bus.rs        = fields.rs;
  assign bus.rt        = fields.rt;
  assign bus.rd        = fields.rd;
  assign bus.shamt     = fields.shamt;
  assign bus.func      = fields.func;
  assign bus.pc        = pc;
  assign bus.inst_cnt  = cnt_q;

endmodule
